// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: valid/ready word intake, one bit per enabled clock on x.
// Optional build macro SER_LSB_FIRST_EN selects LSB-first output (default MSB-first).
module seq_bit_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             bit_en,
  output logic             x,
  output logic             x_valid,
  output logic             done,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SER_LSB_FIRST_EN
  localparam int unsigned OUT_IDX = 0;
`else
  localparam int unsigned OUT_IDX = WIDTH - 1;
`endif

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d, shreg_adv;
  logic [CW-1:0]    cnt, cnt_d;
  logic             last_bit;
  logic             accept;

  assign last_bit  = (cnt == LAST);
  assign din_ready = (state == IDLE) || ((state == SHIFT) && last_bit && bit_en);
  assign accept    = din_valid && din_ready;
  assign busy      = (state == SHIFT);
  assign done      = (state == SHIFT) && last_bit;

`ifdef SER_LSB_FIRST_EN
  assign shreg_adv = {1'b0, shreg[WIDTH-1:1]};
`else
  assign shreg_adv = {shreg[WIDTH-2:0], 1'b0};
`endif

  always_comb begin
    state_d = state;
    shreg_d = shreg;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          shreg_d = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          if (!last_bit) begin
            shreg_d = shreg_adv;
            cnt_d   = cnt + CW'(1);
          end else if (accept) begin
            // Back-to-back reload keeps x_valid high across the word boundary.
            shreg_d = din;
            cnt_d   = '0;
          end else begin
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // x/x_valid are flopped from next-state values so they line up with shreg/state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      cnt     <= cnt_d;
      x       <= (state_d == SHIFT) && shreg_d[OUT_IDX];
      x_valid <= (state_d == SHIFT);
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: queue-based bit-stream model plus literal stream checks.
module tb_seq_bit_serializer;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         bit_en;
  logic         x, x_valid, done, busy;

  int tests = 0;
  int fails = 0;

  seq_bit_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .bit_en    (bit_en),
    .x         (x),
    .x_valid   (x_valid),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending output bits in transmit order, and bits left in the current word.
  bit bq[$];
  int left = 0;
  logic [31:0] cap = '0;
  int capn = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    bit exv, ex, edone, erdy, acc, con;
    if (rst) begin
      bq.delete();
      left = 0;
    end else begin
      exv   = (bq.size() != 0);
      ex    = exv ? bq[0] : 1'b0;
      edone = exv && (left == 1);
      erdy  = !exv || ((left == 1) && bit_en);
      chk("x", 32'(x), 32'(ex));
      chk("x_valid", 32'(x_valid), 32'(exv));
      chk("done", 32'(done), 32'(edone));
      chk("busy", 32'(busy), 32'(exv));
      chk("din_ready", 32'(din_ready), 32'(erdy));
      if (x_valid && bit_en) begin
        cap = {cap[30:0], x};
        capn++;
        if (done) done_cnt++;
      end
      acc = din_valid && erdy;
      con = exv && bit_en;
      if (con) begin
        void'(bq.pop_front());
        left--;
      end
      if (acc) begin
        for (int i = 0; i < int'(W); i++) begin
`ifdef SER_LSB_FIRST_EN
          bq.push_back(din[i]);
`else
          bq.push_back(din[W-1-i]);
`endif
        end
        left = W;
      end
    end
  end

  task automatic cyc(input logic v, input logic [W-1:0] d, input logic en);
    din_valid = v;
    din       = d;
    bit_en    = en;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cap();
    cap = '0;
    capn = 0;
    done_cnt = 0;
  endtask

  initial begin
    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    bit_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_x", 32'(x), 32'd0);
    chk("reset_x_valid", 32'(x_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_din_ready", 32'(din_ready), 32'd1);
    @(posedge clk); #1;

    // Single word 8'h99 (palindrome: same stream either bit order).
    clr_cap();
    cyc(1'b1, 8'h99, 1'b1);
    repeat (9) cyc(1'b0, 8'h00, 1'b1);
    chk("single_stream", cap, 32'h99);
    chk("single_bits", 32'(capn), 32'd8);
    chk("single_done_cnt", 32'(done_cnt), 32'd1);
    chk("single_idle", 32'(busy), 32'd0);

    // Back-to-back 8'h99 then 8'h0F with din_valid held.
    clr_cap();
    cyc(1'b1, 8'h99, 1'b1);
    repeat (8) cyc(1'b1, 8'h0F, 1'b1);
    repeat (10) cyc(1'b0, 8'h00, 1'b1);
`ifdef SER_LSB_FIRST_EN
    chk("b2b_stream", cap, 32'h99F0);
`else
    chk("b2b_stream", cap, 32'h990F);
`endif
    chk("b2b_bits", 32'(capn), 32'd16);
    chk("b2b_done_cnt", 32'(done_cnt), 32'd2);

    // Stall on bit 2 of 8'hA5 for three cycles.
    clr_cap();
    cyc(1'b1, 8'hA5, 1'b1);
    repeat (2) cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'b1;
      din = 8'h3C;
      bit_en = 1'b0;
      #2;
      chk("stall_x", 32'(x), 32'd1);
      chk("stall_ready", 32'(din_ready), 32'd0);
      @(posedge clk); #1;
    end
    repeat (7) cyc(1'b0, 8'h00, 1'b1);
    chk("stall_stream", cap, 32'hA5);
    chk("stall_bits", 32'(capn), 32'd8);

    // din_valid pulsed mid-word must be ignored.
    clr_cap();
    cyc(1'b1, 8'h3C, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'hFF, 1'b1);
    repeat (7) cyc(1'b0, 8'h00, 1'b1);
    chk("hygiene_stream", cap, 32'h3C);
    chk("hygiene_bits", 32'(capn), 32'd8);

    // Asymmetric word pins bit order.
    clr_cap();
    cyc(1'b1, 8'h0B, 1'b1);
    repeat (9) cyc(1'b0, 8'h00, 1'b1);
`ifdef SER_LSB_FIRST_EN
    chk("order_stream", cap, 32'hD0);
`else
    chk("order_stream", cap, 32'h0B);
`endif

    // Reset mid-word: outputs clear asynchronously, no residual bits.
    clr_cap();
    cyc(1'b1, 8'hFF, 1'b1);
    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_x", 32'(x), 32'd0);
    chk("midrst_x_valid", 32'(x_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    chk("midrst_ready", 32'(din_ready), 32'd1);
    @(posedge clk); #1;
    repeat (5) cyc(1'b0, 8'h00, 1'b1);
    chk("midrst_bits", 32'(capn), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_bit_serializer.md
# seq_bit_serializer

Parallel-to-serial front end for the serial sequence-detector chain. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per enabled clock on `x`, the bit stream the detectors consume. A word loads on the last bit of the previous one, so consecutive words reach the detector as a gap-free stream.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `din`  input  WIDTH  parallel word to serialize.
- `din_valid`  input  1  `din` holds a word.
- `din_ready`  output  1  a word will be accepted this cycle; combinational.
- `bit_en`  input  1  advance enable; the current bit is consumed only when this is high.
- `x`  output  1  serial data bit; registered.
- `x_valid`  output  1  `x` carries a word bit; registered.
- `done`  output  1  high while the last bit of a word is on `x`.
- `busy`  output  1  state is SHIFT.

## Operation
- Registers:
  - `shreg[WIDTH-1:0]`
  - `cnt`, $clog2(WIDTH) bits, the index of the current bit
  - `state`, IDLE or SHIFT
- Handshake: a word is accepted on a rising edge where `din_valid && din_ready`.
- Consume: a bit is consumed on an edge where `x_valid && bit_en`.
- `din_ready` = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1 && bit_en).
- IDLE:
  - On accept: `shreg`<=`din`, `cnt`<=0, go to SHIFT.
  - Otherwise hold. `x`=0 and `x_valid`=0.
- SHIFT:
  - `x` = `shreg[WIDTH-1]` and `x_valid`=1.
  - On consume with `cnt`<WIDTH-1: shift `shreg` left by 1, fill with 0, and `cnt`<=`cnt`+1.
  - On consume with `cnt`==WIDTH-1 and accept: reload `shreg`, `cnt`<=0, stay in SHIFT. This is the back-to-back case.
  - On consume with `cnt`==WIDTH-1 and no accept: go to IDLE.
  - `bit_en`=0: all state holds, and `x`/`x_valid` stay stable.
- `done` = (state==SHIFT && cnt==WIDTH-1).
- `din` is sampled only at accept. Later changes to `din` have no effect on the word in flight.
- `din_valid` may be withdrawn at any time; no word is accepted unless `din_ready` is high in the same cycle.

## Timing
- Reset values:
  - `state`=IDLE, `shreg`=0, `cnt`=0
  - `x`=0, `x_valid`=0, `done`=0, `busy`=0
  - `din_ready`=1 after reset is released
- Reset asserted mid-word: the word in flight is discarded immediately, and outputs take their reset values asynchronously.
- Latency: word accepted at edge N puts bit 0 on `x` in cycle N+1. With `bit_en` held high, the last bit appears in cycle N+WIDTH with `done`=1.
- Throughput: one bit per enabled cycle. Back-to-back words leave no idle cycle: `x_valid` stays 1 across the word boundary.
- Stall: while `bit_en`=0, the same bit stays on `x` for any number of cycles. `din_ready` is 0 during a stall in SHIFT.
- `cnt` wraps only through the explicit reload to 0; it never counts past WIDTH-1.

## Configuration
- `SER_LSB_FIRST_EN`
  - Defined: bits leave LSB first. `x` = `shreg[0]` and `shreg` shifts right with 0 fill.
  - Undefined (default): MSB first, as described in Operation.
  - Handshake, counting, timing and `done` are identical in both builds.

## Test plan
- **Reset:** assert `rst` mid-word with WIDTH=8 → `x`=0, `x_valid`=0, `busy`=0 immediately. After release, `din_ready`=1 and no residual bits appear.
- **Single word:** WIDTH=8, `din`=8'h99, `bit_en`=1 → `x` = 1,0,0,1,1,0,0,1 in cycles N+1..N+8, `done` high only in N+8, IDLE in N+9.
- **Back-to-back:**
  - 8'h99, then 8'h0F presented with `din_valid` held high.
  - → `din_ready` pulses only in IDLE and at the cycle of bit 7.
  - → 16 consecutive `x_valid` cycles carrying 1001_1001_0000_1111.
  - → `done` high at cycles 8 and 16.
- **Stall:**
  - 8'hA5, with `bit_en`=0 for 3 cycles after bit 2 is output.
  - → `x`=1 (bit 2) held for 4 cycles and `din_ready`=0 throughout.
  - → the stream resumes 0,0,1,0,1 with `done` on the final bit.
- **Handshake hygiene:** `din_valid` pulsed while `din_ready`=0 mid-word → ignored, and the current word completes unchanged.
- **LSB-first** (`SER_LSB_FIRST_EN` defined, WIDTH=8): 8'h0B → `x` = 1,1,0,1,0,0,0,0.
